// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter sharing one APB master port between NUM_REQ requesters.
// Optional ACCESS-phase watchdog is enabled by defining APB_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | no transfer; arbitrate, latch winner's command, pulse gnt_o
// SETUP  | command latched; APB setup phase (psel only) presented next
// ACCESS | APB setup then access phase visible; wait for pready_i
module apb_rr_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_i,
    input  logic [NUM_REQ-1:0]    req_write_i,
    input  logic [NUM_REQ*AW-1:0] req_addr_i,
    input  logic [NUM_REQ*DW-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]    gnt_o,
    output logic [NUM_REQ-1:0]    done_o,
    output logic [DW-1:0]         rdata_o,
    output logic                  err_o,
    output logic                  psel_o,
    output logic                  penable_o,
    output logic                  pwrite_o,
    output logic [AW-1:0]         paddr_o,
    output logic [DW-1:0]         pwdata_o,
    input  logic                  pready_i,
    input  logic [DW-1:0]         prdata_i
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("apb_rr_arbiter: unsupported parameter set");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t               state, state_d;
    logic [IDX_W-1:0]     ptr, ptr_d;
    logic [IDX_W-1:0]     owner, owner_d;
    logic [IDX_W-1:0]     cand;
    logic [IDX_W-1:0]     win_idx;
    logic [IDX_W-1:0]     win_next;
    logic                 win_found;
    logic [NUM_REQ-1:0]   win_oh;
    logic [NUM_REQ-1:0]   owner_oh;
    logic [AW-1:0]        win_addr;
    logic [DW-1:0]        win_wdata;
    logic                 win_write;

    logic [NUM_REQ-1:0]   gnt_d, done_d;
    logic                 psel_d, pen_d, pwrite_d, err_d;
    logic [AW-1:0]        paddr_d;
    logic [DW-1:0]        pwdata_d, rdata_d;

`ifdef APB_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMR_W-1:0]     tmr, tmr_d;
`endif

    // First requesting index at or above the pointer, wrapping to 0.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
            if (!win_found && req_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign win_next = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

    always_comb begin
        win_oh    = '0;
        owner_oh  = '0;
        win_addr  = '0;
        win_wdata = '0;
        win_write = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            owner_oh[k] = (owner == IDX_W'(k));
            if (win_idx == IDX_W'(k)) begin
                win_oh[k] = 1'b1;
                win_addr  = req_addr_i[k*AW +: AW];
                win_wdata = req_wdata_i[k*DW +: DW];
                win_write = req_write_i[k];
            end
        end
    end

    always_comb begin
        state_d  = state;
        ptr_d    = ptr;
        owner_d  = owner;
        gnt_d    = '0;
        done_d   = '0;
        err_d    = 1'b0;
        psel_d   = psel_o;
        pen_d    = penable_o;
        pwrite_d = pwrite_o;
        paddr_d  = paddr_o;
        pwdata_d = pwdata_o;
        rdata_d  = rdata_o;
`ifdef APB_TIMEOUT_EN
        tmr_d    = tmr;
`endif
        case (state)
            IDLE: begin
                psel_d = 1'b0;
                pen_d  = 1'b0;
                if (win_found) begin
                    state_d  = SETUP;
                    gnt_d    = win_oh;
                    owner_d  = win_idx;
                    ptr_d    = win_next;
                    paddr_d  = win_addr;
                    pwdata_d = win_wdata;
                    pwrite_d = win_write;
                end
            end
            SETUP: begin
                psel_d  = 1'b1;
                pen_d   = 1'b0;
                state_d = ACCESS;
            end
            ACCESS: begin
                // Outputs lag the state by one register, so the first ACCESS
                // cycle is the visible setup phase; pready_i only counts once
                // penable_o is actually high.
                if (!penable_o) begin
                    pen_d = 1'b1;
`ifdef APB_TIMEOUT_EN
                    tmr_d = TMR_W'(TIMEOUT_CYCLES - 1);
`endif
                end else if (pready_i) begin
                    psel_d  = 1'b0;
                    pen_d   = 1'b0;
                    done_d  = owner_oh;
                    state_d = IDLE;
                    if (!pwrite_o) begin
                        rdata_d = prdata_i;
                    end
                end
`ifdef APB_TIMEOUT_EN
                else if (tmr == '0) begin
                    psel_d  = 1'b0;
                    pen_d   = 1'b0;
                    done_d  = owner_oh;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmr_d = tmr - 1'b1;
                end
`endif
            end
            default: begin
                state_d = IDLE;
                psel_d  = 1'b0;
                pen_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            gnt_o     <= '0;
            done_o    <= '0;
            err_o     <= 1'b0;
            psel_o    <= 1'b0;
            penable_o <= 1'b0;
            pwrite_o  <= 1'b0;
            paddr_o   <= '0;
            pwdata_o  <= '0;
            rdata_o   <= '0;
        end else begin
            state     <= state_d;
            ptr       <= ptr_d;
            owner     <= owner_d;
            gnt_o     <= gnt_d;
            done_o    <= done_d;
            err_o     <= err_d;
            psel_o    <= psel_d;
            penable_o <= pen_d;
            pwrite_o  <= pwrite_d;
            paddr_o   <= paddr_d;
            pwdata_o  <= pwdata_d;
            rdata_o   <= rdata_d;
        end
    end

`ifdef APB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmr <= '0;
        end else begin
            tmr <= tmr_d;
        end
    end
`endif

endmodule
